// File: rtl/fifo.sv
// Synchronous single-clock FIFO with one request per cycle selected by wr_rd.
// Storage is a DEPTH x DATA_WIDTH array, addressed by wrapping write/read
// pointers. An occupancy counter drives the full/empty flags, and read data
// is registered.
//
// Request semantics: on every rising clk edge with rstn=1, exactly one request
// is presented. If wr_rd=1 it is a write, accepted only when full=0. If wr_rd=0
// it is a read, accepted only when empty=0. A refused request has no effect at
// all. An accepted read updates data_out at that same edge.
module fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  wr_rd,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  full,
    output logic                  empty,
    output logic [DATA_WIDTH-1:0] data_out
);

    // Pointers are log2(DEPTH) bits, so modulo-DEPTH wrap comes for free.
    // The count needs one more bit so it can represent DEPTH itself.
    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0]         wr_ptr_q,   wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q,   rd_ptr_d;
    logic [CNT_W-1:0]      count_q,    count_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;

    logic wr_en;
    logic rd_en;

    // Flag decode reflects the state left by the most recent edge.
    always_comb begin
        full  = (count_q == CNT_FULL);
        empty = (count_q == '0);
    end

    // Qualify the single request against the current flags.
    always_comb begin
        wr_en = 1'b0;
        rd_en = 1'b0;
        if (wr_rd) begin
            wr_en = !full;
        end else begin
            rd_en = !empty;
        end
    end

    // Next-state for pointers, count and the read data register.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        data_out_d = data_out_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            count_d  = count_q + 1'b1;
        end
        if (rd_en) begin
            data_out_d = mem_q[rd_ptr_q];
            rd_ptr_d   = rd_ptr_q + 1'b1;
            count_d    = count_q - 1'b1;
        end
    end

    // Control state register. Reset wins over any request in the same cycle.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            data_out_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            data_out_q <= data_out_d;
        end
    end

    // Storage write port. Contents are not reset: after a reset the old
    // entries become unreachable because both pointers and the count restart.
    always_ff @(posedge clk) begin
        if (rstn && wr_en) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    assign data_out = data_out_q;

    // Structural invariants tying the count to the flags.
    a_count_range : assert property (@(posedge clk) disable iff (!rstn)
        count_q <= CNT_FULL);
    a_flags_exclusive : assert property (@(posedge clk) disable iff (!rstn)
        !(full && empty));
    a_ptr_distance : assert property (@(posedge clk) disable iff (!rstn)
        (count_q == CNT_FULL || count_q == '0) ? (wr_ptr_q == rd_ptr_q)
                                                : (wr_ptr_q != rd_ptr_q));

endmodule

// File: tb/tb_fifo.sv
// Directed bench for fifo: reset, fill/overflow, drain/underflow, wrap,
// interleave and mid-stream reset, with hand-computed expected values.
module tb_fifo;

    localparam int DW = 8;

    logic          clk;
    logic          rstn;
    logic          wr_rd;
    logic [DW-1:0] data_in;
    logic          full;
    logic          empty;
    logic [DW-1:0] data_out;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] exp_q[$];

    fifo #(.DATA_WIDTH(DW), .DEPTH(16)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .wr_rd    (wr_rd),
        .data_in  (data_in),
        .full     (full),
        .empty    (empty),
        .data_out (data_out)
    );

    // Clock generation.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single checking task: counts and reports.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive on the falling edge, sample 1 ns after rising edge.
    task automatic cycle(input logic rst_n, input logic op, input logic [DW-1:0] din);
        @(negedge clk);
        rstn    = rst_n;
        wr_rd   = op;
        data_in = din;
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [DW-1:0] din);
        cycle(1'b1, 1'b1, din);
    endtask

    task automatic do_read();
        cycle(1'b1, 1'b0, '0);
    endtask

    initial begin
        logic [DW-1:0] exp_v;
        rstn    = 1'b0;
        wr_rd   = 1'b0;
        data_in = '0;

        // Reset for one edge.
        cycle(1'b0, 1'b1, 8'hEE);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_dout", data_out, 8'h00);

        // Fill with 0x00..0x1F: full after the 16th write, rest dropped.
        for (int i = 0; i < 32; i++) begin
            do_write(DW'(i));
            check("fill_empty", empty, 0);
            check("fill_full", full, (i >= 15) ? 1 : 0);
            check("fill_dout_hold", data_out, 8'h00);
        end

        // Drain: 0x00..0x0F, then underflow reads hold 0x0F.
        for (int i = 0; i < 32; i++) begin
            do_read();
            check("drain_dout", data_out, (i < 16) ? i : 8'h0F);
            check("drain_empty", empty, (i >= 15) ? 1 : 0);
            check("drain_full", full, 0);
        end

        // Wrap: advance pointers by 10, then fill 0xA0..0xAF across the wrap.
        for (int i = 0; i < 10; i++) do_write(8'h30 + DW'(i));
        for (int i = 0; i < 10; i++) begin
            do_read();
            check("wrap_pre_dout", data_out, 8'h30 + i);
        end
        check("wrap_pre_empty", empty, 1);
        for (int i = 0; i < 16; i++) begin
            do_write(8'hA0 + DW'(i));
            exp_q.push_back(8'hA0 + DW'(i));
            check("wrap_wr_hold", data_out, 8'h39);
        end
        check("wrap_full", full, 1);
        do_write(8'h77);
        check("wrap_ovf_full", full, 1);
        for (int i = 0; i < 16; i++) begin
            do_read();
            exp_v = exp_q.pop_front();
            check("wrap_dout", data_out, exp_v);
            check("wrap_full_clr", full, 0);
        end
        check("wrap_empty", empty, 1);

        // Interleave.
        do_write(8'h55);
        check("il_wr1_empty", empty, 0);
        do_read();
        check("il_rd1_dout", data_out, 8'h55);
        check("il_rd1_empty", empty, 1);
        do_write(8'h66);
        check("il_wr2_hold", data_out, 8'h55);
        do_read();
        check("il_rd2_dout", data_out, 8'h66);
        check("il_rd2_empty", empty, 1);

        // Mid-operation reset with a write request presented: reset wins.
        for (int i = 0; i < 5; i++) do_write(8'hC0 + DW'(i));
        check("mid_pre_empty", empty, 0);
        cycle(1'b0, 1'b1, 8'hFF);
        check("mid_rst_empty", empty, 1);
        check("mid_rst_full", full, 0);
        check("mid_rst_dout", data_out, 8'h00);
        do_read();
        check("mid_rd_empty", empty, 1);
        check("mid_rd_dout", data_out, 8'h00);

        // Fresh write after reset comes back first.
        do_write(8'h5A);
        do_read();
        check("post_rst_dout", data_out, 8'h5A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
